// File: rtl/maze_port_arbiter.sv
// Shares one single-port maze BRAM between the pixel renderer (one-entry tile cache)
// and three round-robin query requesters (pacman, ghost1, ghost2).
module maze_port_arbiter #(
    parameter int MAZE_COLS = 28,
    parameter int MAZE_ROWS = 31
) (
    input  logic        clk_25MHz,
    input  logic        Reset,
    input  logic        render_active,
    input  logic [4:0]  render_row,
    input  logic [4:0]  render_col,
    output logic        render_wall,
    input  logic [2:0]  q_req,
    input  logic [14:0] q_row,
    input  logic [14:0] q_col,
    output logic [2:0]  q_ack,
    output logic [2:0]  q_valid,
    output logic        q_wall,
    output logic [4:0]  rom_row,
    output logic [4:0]  rom_col,
    input  logic        rom_data
);

    localparam logic [5:0] ROW_LIM = 6'(MAZE_ROWS);
    localparam logic [5:0] COL_LIM = 6'(MAZE_COLS);

    // Where next cycle's render_wall comes from.
    typedef enum logic [1:0] {
        RW_ZERO  = 2'd0,
        RW_ROM   = 2'd1,
        RW_CACHE = 2'd2
    } rw_sel_e;

    function automatic logic addr_ok(input logic [4:0] row, input logic [4:0] col);
        return ({1'b0, row} < ROW_LIM) && ({1'b0, col} < COL_LIM);
    endfunction

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        case (idx)
            2'd0:    return 2'd1;
            2'd1:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [4:0] slice5(input logic [14:0] bus, input logic [1:0] idx);
        case (idx)
            2'd0:    return bus[4:0];
            2'd1:    return bus[9:5];
            default: return bus[14:10];
        endcase
    endfunction

    logic [1:0] ptr_q, ptr_d;
    logic       cache_valid_q;
    logic [4:0] cache_row_q, cache_col_q;
    logic       cache_data_q;
    rw_sel_e    rw_sel_q, rw_sel_d;
    logic [2:0] q_valid_q;
    logic       q_oob_q;

    logic       render_ok_s, render_hit_s, render_miss_s;
    logic       gnt_found_s;
    logic [1:0] gnt_idx_s, cand_s;
    logic [4:0] gnt_row_s, gnt_col_s;
    logic [2:0] q_ack_s;

    // Render cache lookup; a miss claims the BRAM port this cycle.
    always_comb begin
        render_ok_s   = addr_ok(render_row, render_col);
        render_hit_s  = cache_valid_q && (cache_row_q == render_row) && (cache_col_q == render_col);
        render_miss_s = !Reset && render_active && render_ok_s && !render_hit_s;
        if (render_active && render_ok_s) begin
            rw_sel_d = render_miss_s ? RW_ROM : RW_CACHE;
        end else begin
            rw_sel_d = RW_ZERO;
        end
    end

    // Round-robin query grant, searching from the pointer, only when render leaves the port free.
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_idx_s   = ptr_q;
        cand_s      = ptr_q;
        if (!Reset && !render_miss_s) begin
            for (int k = 0; k < 3; k++) begin
                if (!gnt_found_s && q_req[cand_s]) begin
                    gnt_found_s = 1'b1;
                    gnt_idx_s   = cand_s;
                end
                cand_s = rr_next(cand_s);
            end
        end else begin
            gnt_found_s = 1'b0;
        end
        q_ack_s   = gnt_found_s ? (3'b001 << gnt_idx_s) : 3'b000;
        gnt_row_s = slice5(q_row, gnt_idx_s);
        gnt_col_s = slice5(q_col, gnt_idx_s);
        ptr_d     = gnt_found_s ? rr_next(gnt_idx_s) : ptr_q;
    end

    // BRAM address mux: render miss, granted query, or parked at zero.
    always_comb begin
        if (render_miss_s) begin
            rom_row = render_row;
            rom_col = render_col;
        end else if (gnt_found_s) begin
            rom_row = gnt_row_s;
            rom_col = gnt_col_s;
        end else begin
            rom_row = 5'd0;
            rom_col = 5'd0;
        end
    end

    assign q_ack = q_ack_s;

    // Responses; Reset squashes anything still in flight from the previous cycle.
    always_comb begin
        render_wall = 1'b0;
        if (Reset) begin
            render_wall = 1'b0;
        end else begin
            case (rw_sel_q)
                RW_ROM:   render_wall = rom_data;
                RW_CACHE: render_wall = cache_data_q;
                default:  render_wall = 1'b0;
            endcase
        end
        q_valid = Reset ? 3'b000 : q_valid_q;
        q_wall  = (!Reset && (|q_valid_q)) ? (q_oob_q | rom_data) : 1'b0;
    end

    // State update; the cache data bit fills the cycle after its miss, when rom_data is valid.
    always_ff @(posedge clk_25MHz) begin
        if (Reset) begin
            ptr_q         <= 2'd0;
            cache_valid_q <= 1'b0;
            cache_row_q   <= 5'd0;
            cache_col_q   <= 5'd0;
            cache_data_q  <= 1'b0;
            rw_sel_q      <= RW_ZERO;
            q_valid_q     <= 3'b000;
            q_oob_q       <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            rw_sel_q  <= rw_sel_d;
            q_valid_q <= q_ack_s;
            q_oob_q   <= gnt_found_s && !addr_ok(gnt_row_s, gnt_col_s);
            if (render_miss_s) begin
                cache_valid_q <= 1'b1;
                cache_row_q   <= render_row;
                cache_col_q   <= render_col;
            end
            if (rw_sel_q == RW_ROM) begin
                cache_data_q <= rom_data;
            end
        end
    end

endmodule

// File: tb/tb_maze_port_arbiter.sv
// Randomized and directed bench for maze_port_arbiter against a tile-level reference model.
module tb_maze_port_arbiter;

    localparam int COLS = 28;
    localparam int ROWS = 31;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        render_active = 1'b0;
    logic [4:0]  render_row = 5'd0, render_col = 5'd0;
    logic        render_wall;
    logic [2:0]  q_req = 3'b000;
    logic [14:0] q_row = 15'd0, q_col = 15'd0;
    logic [2:0]  q_ack, q_valid;
    logic        q_wall;
    logic [4:0]  rom_row, rom_col;
    logic        rom_data = 1'b0;

    int checks = 0;
    int errors = 0;

    bit maze [0:31][0:31];

    // Reference model state: cache as a (valid,row,col) record, pointer as an integer.
    bit       m_cvalid = 1'b0;
    int       m_crow = 0, m_ccol = 0;
    int       m_ptr = 0;
    bit       m_rw = 1'b0, m_qw = 1'b0;
    bit [2:0] m_qv = 3'b000;
    bit [2:0] last_ack;
    int       wait_c [3];

    maze_port_arbiter #(.MAZE_COLS(COLS), .MAZE_ROWS(ROWS)) dut (
        .clk_25MHz    (clk),
        .Reset        (Reset),
        .render_active(render_active),
        .render_row   (render_row),
        .render_col   (render_col),
        .render_wall  (render_wall),
        .q_req        (q_req),
        .q_row        (q_row),
        .q_col        (q_col),
        .q_ack        (q_ack),
        .q_valid      (q_valid),
        .q_wall       (q_wall),
        .rom_row      (rom_row),
        .rom_col      (rom_col),
        .rom_data     (rom_data)
    );

    always #20 clk = ~clk;

    // Behavioural single-port BRAM with one cycle read latency.
    always @(posedge clk) rom_data <= maze[rom_row][rom_col];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: inputs already driven after a negedge.
    task automatic tick();
        bit [2:0] e_ack;
        int       e_rr, e_rc, r, c, gi;
        bit       n_rw, n_qw, miss, inr;
        bit [2:0] n_qv;
        e_ack = 3'b000; e_rr = 0; e_rc = 0; gi = 0;
        n_rw = 1'b0; n_qw = 1'b0; n_qv = 3'b000; miss = 1'b0;
        r = int'(render_row); c = int'(render_col);
        if (!Reset) begin
            inr  = (r < ROWS) && (c < COLS);
            miss = render_active && inr && !(m_cvalid && m_crow == r && m_ccol == c);
            if (render_active && inr) n_rw = maze[r][c];
            if (miss) begin
                e_rr = r; e_rc = c;
            end else begin
                for (int k = 0; k < 3; k++) begin
                    int idx;
                    idx = (m_ptr + k) % 3;
                    if (e_ack == 3'b000 && q_req[idx]) begin
                        gi    = idx;
                        e_ack = 3'(1 << idx);
                        e_rr  = int'(q_row[5*idx +: 5]);
                        e_rc  = int'(q_col[5*idx +: 5]);
                        n_qv  = e_ack;
                        n_qw  = (e_rr >= ROWS || e_rc >= COLS) ? 1'b1 : maze[e_rr][e_rc];
                    end
                end
            end
        end
        #2;
        chk("q_ack", 32'(q_ack), 32'(e_ack));
        chk("rom_row", 32'(rom_row), 32'(e_rr));
        chk("rom_col", 32'(rom_col), 32'(e_rc));
        chk("render_wall", 32'(render_wall), Reset ? 32'd0 : 32'(m_rw));
        chk("q_valid", 32'(q_valid), Reset ? 32'd0 : 32'(m_qv));
        chk("q_wall", 32'(q_wall), Reset ? 32'd0 : 32'(m_qw));
        for (int i = 0; i < 3; i++) begin
            if (Reset) begin
                wait_c[i] = 0;
            end else if (e_ack[i]) begin
                chk("ack_latency_le20", 32'(wait_c[i] <= 20), 32'd1);
                wait_c[i] = 0;
            end else if (q_req[i]) begin
                wait_c[i]++;
                if (wait_c[i] == 21) chk("request_starved", 32'd0, 32'd1);
            end else begin
                wait_c[i] = 0;
            end
        end
        last_ack = e_ack;
        @(posedge clk);
        if (Reset) begin
            m_cvalid = 1'b0; m_ptr = 0; m_rw = 1'b0; m_qv = 3'b000; m_qw = 1'b0;
        end else begin
            if (miss) begin
                m_cvalid = 1'b1; m_crow = r; m_ccol = c;
            end
            if (e_ack != 3'b000) m_ptr = (gi + 1) % 3;
            m_rw = n_rw; m_qv = n_qv; m_qw = n_qw;
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit act, input int row, input int col, input bit [2:0] req);
        render_active = act;
        render_row    = 5'(row);
        render_col    = 5'(col);
        q_req         = req;
    endtask

    task automatic set_q(input int i, input int row, input int col);
        q_row[5*i +: 5] = 5'(row);
        q_col[5*i +: 5] = 5'(col);
    endtask

    initial begin
        bit pend [3];
        int pr [3], pc [3];
        int tile_cnt, rr, rc;
        for (int i = 0; i < 32; i++)
            for (int j = 0; j < 32; j++)
                maze[i][j] = 1'($urandom_range(0, 1));
        maze[2][3] = 1'b1;
        maze[31][0] = 1'b0;
        maze[5][6] = 1'b1;
        for (int i = 0; i < 3; i++) wait_c[i] = 0;
        @(negedge clk);
        tick(); tick();

        // Render of (2,3) held 17 cycles: one miss then hits.
        Reset = 1'b0;
        drive(1'b1, 2, 3, 3'b000);
        repeat (17) tick();

        // ghost1 request collides with a render miss, then wins the next cycle.
        set_q(1, 5, 6);
        drive(1'b1, 4, 4, 3'b010);
        tick(); tick();
        drive(1'b1, 4, 4, 3'b000);
        tick(); tick();

        // All three requesting continuously from pointer 0.
        Reset = 1'b1; tick(); Reset = 1'b0;
        set_q(0, 1, 2); set_q(1, 3, 4); set_q(2, 10, 27);
        drive(1'b0, 0, 0, 3'b111);
        repeat (5) tick();
        drive(1'b0, 0, 0, 3'b000);
        tick(); tick();

        // Out-of-range pacman query reports a wall.
        set_q(0, 31, 0);
        drive(1'b0, 0, 0, 3'b001);
        tick();
        drive(1'b0, 0, 0, 3'b000);
        tick(); tick();

        // Out-of-range render leaves the port to ghost2.
        set_q(2, 7, 7);
        drive(1'b1, 0, 28, 3'b100);
        tick();
        drive(1'b1, 0, 28, 3'b000);
        tick(); tick();

        // Grant immediately followed by Reset: no response; cache cold afterwards.
        set_q(0, 1, 1);
        drive(1'b0, 0, 0, 3'b001);
        tick();
        Reset = 1'b1;
        drive(1'b0, 0, 0, 3'b000);
        tick();
        Reset = 1'b0;
        drive(1'b1, 2, 3, 3'b000);
        tick(); tick(); tick();

        // Randomized traffic with the renderer changing tile at most once per 17 cycles.
        for (int i = 0; i < 3; i++) begin pend[i] = 1'b0; pr[i] = 0; pc[i] = 0; end
        tile_cnt = 0; rr = 0; rc = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    pr[i] = $urandom_range(0, 31);
                    pc[i] = $urandom_range(0, 31);
                end
                set_q(i, pr[i], pc[i]);
                q_req[i] = pend[i];
            end
            if (tile_cnt == 0) begin
                rr = $urandom_range(0, 31);
                rc = $urandom_range(0, 31);
                tile_cnt = $urandom_range(17, 24);
            end
            tile_cnt--;
            render_active = ($urandom_range(0, 3) != 0);
            render_row = 5'(rr);
            render_col = 5'(rc);
            Reset = ($urandom_range(0, 299) == 0);
            tick();
            for (int i = 0; i < 3; i++)
                if (last_ack[i]) pend[i] = 1'b0;
        end
        Reset = 1'b0;
        drive(1'b0, 0, 0, 3'b000);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
